uart_alu_top: RTL and testbench

//  UART-controlled 8-bit ALU. It receives three 8N1 bytes on i_rx: operand A, operand B, then the opcode.
//  It computes A op B and transmits the 8-bit result on o_tx.
//  Top of the board-level UART/ALU test design; debug outputs expose the latest result, instruction and received byte.

---
 rtl/uart_alu_pkg.sv | 20 ++
 rtl/alu8.sv | 29 ++
 rtl/uart_rx.sv | 72 +++++++
 rtl/uart_tx.sv | 71 +++++++
 rtl/uart_alu_top.sv | 101 ++++++++++
 tb/tb_uart_alu_top.sv | 187 ++++++++++++++++++
 6 files changed

// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-controlled ALU: opcodes, FSM state types, default timing.
package uart_alu_pkg;

  localparam int DEF_CLK_FREQ  = 50_000_000;
  localparam int DEF_BAUD_RATE = 19_200;

  localparam logic [5:0] OP_SRL = 6'h02;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;

  typedef enum logic [1:0] {WAIT_A, WAIT_B, WAIT_OP, EXEC} ctrl_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

endpackage

// File: rtl/alu8.sv
// Combinational 8-bit ALU; opcode is the low 6 bits of the received OP byte.
module alu8
  import uart_alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [5:0] op,
  output logic [7:0] y
);

  logic big_shift;

  always_comb begin
    big_shift = (b > 8'd7);
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      OP_SRL:  y = big_shift ? '0 : (a >> b[2:0]);
      OP_SRA:  y = big_shift ? {8{a[7]}} : $unsigned($signed(a) >>> b[2:0]);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer, mid-bit sampling and glitch rejection.
module uart_rx
  import uart_alu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 rx,
  output logic                 done,
  output logic [DATA_BITS-1:0] data
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  rx_state_e state, state_n;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_m, rx_s, rx_p, tick;

  // The start bit is checked at its midpoint; every later sample is one full bit apart.
  assign tick = (state == RX_START) ? (cnt == CW'(CLKS_PER_BIT/2 - 1))
                                    : (cnt == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_n = state;
    case (state)
      RX_IDLE:  if (rx_p && !rx_s) state_n = RX_START;
      RX_START: if (tick) state_n = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_idx == BW'(DATA_BITS - 1)) state_n = RX_STOP;
      RX_STOP:  if (tick) state_n = RX_IDLE;
      default:  state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state   <= RX_IDLE;
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_p    <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      done    <= 1'b0;
      data    <= '0;
    end else begin
      rx_m  <= rx;
      rx_s  <= rx_m;
      rx_p  <= rx_s;
      state <= state_n;
      cnt   <= (state == RX_IDLE || tick) ? '0 : cnt + CW'(1);
      done  <= 1'b0;
      case (state)
        RX_START: bit_idx <= '0;
        RX_DATA: if (tick) begin
          shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
          bit_idx <= bit_idx + BW'(1);
        end
        RX_STOP: if (tick && rx_s) begin
          done <= 1'b1;
          data <= shreg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; output bit is registered so o_tx is glitch-free and resets high.
module uart_tx
  import uart_alu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  tx_state_e state, state_n;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick, tx_n;

  assign tick = (cnt == CW'(CLKS_PER_BIT - 1));
  assign busy = (state != TX_IDLE);

  always_comb begin
    state_n = state;
    case (state)
      TX_IDLE:  if (start) state_n = TX_START;
      TX_START: if (tick) state_n = TX_DATA;
      TX_DATA:  if (tick && bit_idx == BW'(DATA_BITS - 1)) state_n = TX_STOP;
      TX_STOP:  if (tick) state_n = TX_IDLE;
      default:  state_n = TX_IDLE;
    endcase
    // Line level follows the next state; on a data-bit boundary the next bit is shreg[1].
    tx_n = 1'b1;
    case (state_n)
      TX_START: tx_n = 1'b0;
      TX_DATA:  tx_n = (state == TX_DATA && tick) ? shreg[1] : shreg[0];
      default:  tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state   <= TX_IDLE;
      tx      <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state <= state_n;
      tx    <= tx_n;
      cnt   <= (state == TX_IDLE || tick) ? '0 : cnt + CW'(1);
      case (state)
        TX_IDLE: if (start) begin
          shreg   <= data;
          bit_idx <= '0;
        end
        TX_DATA: if (tick) begin
          shreg   <= shreg >> 1;
          bit_idx <= bit_idx + BW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_alu_top.sv
// UART/ALU top: receives A, B, OP bytes, transmits A op B. Optional echo of every accepted
// byte is enabled by defining UART_ALU_ECHO_EN.
module uart_alu_top
  import uart_alu_pkg::*;
#(
  parameter int CLK_FREQ     = DEF_CLK_FREQ,
  parameter int BAUD_RATE    = DEF_BAUD_RATE,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
  parameter int DATA_BITS    = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_rx,
  output logic        o_tx,
  output logic [7:0]  result,
  output logic [31:0] o_inst,
  output logic [7:0]  COMM_result
);

  ctrl_state_e state, state_n;
  logic [7:0] reg_a, reg_b, reg_op, alu_y, rx_data, tx_data;
  logic       rx_done, tx_start, tx_busy, exec_fire;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT), .DATA_BITS(DATA_BITS)) u_rx (
    .i_clk(i_clk), .i_reset(i_reset), .rx(i_rx), .done(rx_done), .data(rx_data)
  );

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT), .DATA_BITS(DATA_BITS)) u_tx (
    .i_clk(i_clk), .i_reset(i_reset), .start(tx_start), .data(tx_data),
    .tx(o_tx), .busy(tx_busy)
  );

  alu8 u_alu (.a(reg_a), .b(reg_b), .op(reg_op[5:0]), .y(alu_y));

  assign COMM_result = rx_data;

`ifdef UART_ALU_ECHO_EN
  logic       echo_pend, echo_fire;
  logic [7:0] echo_byte;

  // A pending echo always goes out before the result, so the result is the last frame.
  assign echo_fire = echo_pend && !tx_busy;
  assign exec_fire = (state == EXEC) && !tx_busy && !echo_pend;
  assign tx_start  = echo_fire || exec_fire;
  assign tx_data   = echo_fire ? echo_byte : alu_y;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      echo_pend <= 1'b0;
      echo_byte <= '0;
    end else begin
      if (echo_fire) echo_pend <= 1'b0;
      if (rx_done && state != EXEC) begin
        echo_pend <= 1'b1;
        echo_byte <= rx_data;
      end
    end
  end
`else
  assign exec_fire = (state == EXEC) && !tx_busy;
  assign tx_start  = exec_fire;
  assign tx_data   = alu_y;
`endif

  always_comb begin
    state_n = state;
    case (state)
      WAIT_A:  if (rx_done) state_n = WAIT_B;
      WAIT_B:  if (rx_done) state_n = WAIT_OP;
      WAIT_OP: if (rx_done) state_n = EXEC;
      EXEC:    if (exec_fire) state_n = WAIT_A;
      default: state_n = WAIT_A;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state  <= WAIT_A;
      reg_a  <= '0;
      reg_b  <= '0;
      reg_op <= '0;
      result <= '0;
      o_inst <= '0;
    end else begin
      state <= state_n;
      if (rx_done) begin
        case (state)
          WAIT_A:  reg_a  <= rx_data;
          WAIT_B:  reg_b  <= rx_data;
          WAIT_OP: reg_op <= rx_data;
          default: ;
        endcase
      end
      if (exec_fire) begin
        result <= alu_y;
        o_inst <= {8'h00, reg_op, reg_b, reg_a};
      end
    end
  end

endmodule

// File: tb/tb_uart_alu_top.sv
// Directed bench for uart_alu_top: drives serial triples, decodes o_tx frames, checks outputs.
`timescale 1ns/1ps
module tb_uart_alu_top;

  localparam int CPB = 80;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        tx;
  logic [7:0]  result, comm;
  logic [31:0] inst;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rst_cnt  = 0;
  int stop_t   = 0;
  logic [7:0] frames[$];
  int         frame_t[$];

  uart_alu_top #(
    .CLK_FREQ(25_000_000), .BAUD_RATE(312_500), .CLKS_PER_BIT(CPB), .DATA_BITS(8)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_rx(rx), .o_tx(tx),
    .result(result), .o_inst(inst), .COMM_result(comm)
  );

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge rst_n) rst_cnt++;

  // Frame decoder: any frame overlapping a reset is discarded.
  always begin : mon
    logic [7:0] b;
    logic       ok;
    int         t0, r0;
    @(negedge tx);
    t0 = cyc;
    r0 = rst_cnt;
    repeat (CPB/2) @(posedge clk);
    #1 ok = (tx == 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk);
      #1 b[i] = tx;
    end
    repeat (CPB) @(posedge clk);
    #1;
    if (ok && tx && r0 == rst_cnt) begin
      frames.push_back(b);
      frame_t.push_back(t0);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    stop_t = cyc;
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_frame(output logic [7:0] v, output int t, output bit got);
    got = 1'b0;
    v = '0;
    t = 0;
    for (int i = 0; i < 16*CPB && !got; i++) begin
      @(negedge clk);
      if (frames.size() > 0) begin
        v = frames.pop_front();
        t = frame_t.pop_front();
        got = 1'b1;
      end
    end
  endtask

  task automatic run_triple(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] op, input logic [7:0] exp);
    logic [7:0] fv;
    int         ft, lat;
    bit         got;
    frames.delete();
    frame_t.delete();
    send_byte(a, 1'b1);
    send_byte(b, 1'b1);
    send_byte(op, 1'b1);
    wait_frame(fv, ft, got);
    check({tag, "_frame_seen"}, 32'(got), 32'd1);
    if (got) begin
      lat = ft - stop_t;
      check({tag, "_frame"}, 32'(fv), 32'(exp));
      check({tag, "_latency_ok"}, 32'(lat >= CPB/2 - 2 && lat <= CPB/2 + 10), 32'd1);
    end
    check({tag, "_result"}, 32'(result), 32'(exp));
    check({tag, "_inst"}, inst, {8'h00, op, b, a});
    check({tag, "_comm"}, 32'(comm), 32'(op));
  endtask

  initial begin : watchdog
    #(95_000 * 40);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit got;
    repeat (5) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_result", 32'(result), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_comm", 32'(comm), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_tx", 32'(tx), 32'd1);

    run_triple("add",      8'h20, 8'h20, 8'h20, 8'h40);
    run_triple("sub",      8'h05, 8'h07, 8'h22, 8'hFE);
    run_triple("nor",      8'hF0, 8'h0F, 8'h27, 8'h00);
    run_triple("sra",      8'h80, 8'h02, 8'h03, 8'hE0);
    run_triple("srl",      8'h80, 8'h02, 8'h02, 8'h20);
    run_triple("sra_big",  8'h80, 8'h09, 8'h03, 8'hFF);
    run_triple("srl_big",  8'h80, 8'h08, 8'h02, 8'h00);
    run_triple("undef",    8'h12, 8'h34, 8'h3F, 8'h00);
    run_triple("and",      8'hCA, 8'h5F, 8'h24, 8'h4A);
    run_triple("xor",      8'hFF, 8'h0F, 8'h26, 8'hF0);
    run_triple("add_hiop", 8'hFF, 8'h02, 8'hE0, 8'h01);

    // Short low pulse must be rejected; a frame with a bad stop bit must be dropped.
    frames.delete();
    @(negedge clk);
    rx = 1'b0;
    #1000;
    rx = 1'b1;
    repeat (2*CPB) @(negedge clk);
    check("glitch_comm", 32'(comm), 32'hE0);
    send_byte(8'h5A, 1'b0);
    repeat (2*CPB) @(negedge clk);
    check("ferr_comm", 32'(comm), 32'hE0);
    check("ferr_noframe", 32'(frames.size()), 32'd0);
    check("ferr_result", 32'(result), 32'h01);
    run_triple("post_err", 8'h11, 8'h22, 8'h20, 8'h33);

    // Reset in the middle of a result frame.
    frames.delete();
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h20, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 4*CPB && !got; i++) begin
      @(negedge clk);
      if (tx == 1'b0) got = 1'b1;
    end
    check("rst_mid_txstart", 32'(got), 32'd1);
    repeat (3*CPB + CPB/2) @(negedge clk);
    check("pre_rst_result", 32'(result), 32'h07);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_inst", inst, 32'd0);
    check("mid_rst_comm", 32'(comm), 32'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (12*CPB) @(negedge clk);
    check("mid_rst_tx_idle", 32'(tx), 32'd1);
    check("mid_rst_noframe", 32'(frames.size()), 32'd0);
    run_triple("post_rst", 8'h09, 8'h03, 8'h22, 8'h06);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
